// File: rtl/playback_sequencer.sv
// Playback sequencer: walks the stored-note slots, gating the tone generator per note
// with a FETCH (read settle) / NOTE (audible) / GAP (silent) cadence.
module playback_sequencer #(
    parameter int NOTE_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int READ_LAT   = 2,
    parameter int START_SLOT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [4:0] num_notes,
    output logic       ld_play,
    output logic [3:0] note_counter,
    output logic       audio_en,
    output logic       busy,
    output logic       done
);

    localparam int MAX_NG  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int MAX_ALL = (MAX_NG > READ_LAT) ? MAX_NG : READ_LAT;
    localparam int TICK_W  = $clog2(MAX_ALL + 1);

    // The tick counter is loaded with (duration - 1) and counts down to zero, so every
    // state lasts exactly its duration; READ_LAT is assumed to be at least 1.
    localparam logic [TICK_W-1:0] FETCH_LOAD = TICK_W'(READ_LAT - 1);
    localparam logic [TICK_W-1:0] NOTE_LOAD  = TICK_W'(NOTE_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LOAD   = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [3:0]        FIRST_SLOT = 4'(START_SLOT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        NOTE,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [4:0]        idx;
    logic [4:0]        n;
    logic [4:0]        n_clamped;

    assign n_clamped = (num_notes > 5'd16) ? 5'd16 : num_notes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ld_play      <= 1'b0;
            note_counter <= FIRST_SLOT;
            audio_en     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick         <= '0;
            idx          <= '0;
            n            <= '0;
        end else begin
            done <= 1'b0;
            // stop overrides every active state and drops the datapath controls on this edge
            if (stop && (state inside {FETCH, NOTE, GAP})) begin
                state    <= DONE;
                done     <= 1'b1;
                ld_play  <= 1'b0;
                audio_en <= 1'b0;
                tick     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop && (num_notes != 5'd0)) begin
                            n            <= n_clamped;
                            note_counter <= FIRST_SLOT;
                            idx          <= '0;
                            tick         <= FETCH_LOAD;
                            ld_play      <= 1'b1;
                            busy         <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (tick == '0) begin
                            tick     <= NOTE_LOAD;
                            audio_en <= 1'b1;
                            state    <= NOTE;
                        end else begin
                            tick <= tick - TICK_ONE;
                        end
                    end
                    NOTE: begin
                        if (tick == '0) begin
                            tick     <= GAP_LOAD;
                            audio_en <= 1'b0;
                            state    <= GAP;
                        end else begin
                            tick <= tick - TICK_ONE;
                        end
                    end
                    GAP: begin
                        if (tick == '0) begin
                            if (idx < (n - 5'd1)) begin
                                idx          <= idx + 5'd1;
                                note_counter <= note_counter + 4'd1;
                                tick         <= FETCH_LOAD;
                                state        <= FETCH;
                            end else if (loop_en) begin
                                idx          <= '0;
                                note_counter <= FIRST_SLOT;
                                tick         <= FETCH_LOAD;
                                state        <= FETCH;
                            end else begin
                                done    <= 1'b1;
                                ld_play <= 1'b0;
                                tick    <= '0;
                                state   <= DONE;
                            end
                        end else begin
                            tick <= tick - TICK_ONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        ld_play  <= 1'b0;
                        audio_en <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer with short note timing (NOTE=8, GAP=2, READ_LAT=2).
module tb_playback_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [4:0] num_notes = 5'd0;
    logic       ld_play;
    logic [3:0] note_counter;
    logic       audio_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [3:0] bursts[$];
    logic prev_aud = 1'b0;

    playback_sequencer #(
        .NOTE_TICKS(8),
        .GAP_TICKS (2),
        .READ_LAT  (2),
        .START_SLOT(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .num_notes   (num_notes),
        .ld_play     (ld_play),
        .note_counter(note_counter),
        .audio_en    (audio_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Counts done pulses and records the slot played at each audio_en rising edge.
    always @(negedge clk) begin
        if (done) done_count++;
        if (audio_en && !prev_aud) bursts.push_back(note_counter);
        prev_aud = audio_en;
    end

    typedef struct {
        logic       start;
        logic       stop;
        logic       loop_en;
        logic [4:0] num_notes;
        int         edges;
        logic [7:0] expected;
        string      name;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic st, logic sp, logic lp, logic [4:0] nn, int ed,
                                logic l, logic [3:0] nc, logic a, logic b, logic d, string nm);
        vec_t v;
        v.start     = st;
        v.stop      = sp;
        v.loop_en   = lp;
        v.num_notes = nn;
        v.edges     = ed;
        v.expected  = {l, nc, a, b, d};
        v.name      = nm;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {ld_play, note_counter, audio_en, busy, done};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        stop      = v.stop;
        loop_en   = v.loop_en;
        num_notes = v.num_notes;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        if (v.edges > 1) step(v.edges - 1);
        checkOutput(v.name, int'(outs()), int'(v.expected));
    endtask

    task automatic pulse_start(input logic [4:0] nn);
        start     = 1'b1;
        num_notes = nn;
        step(1);
        start = 1'b0;
    endtask

    // Returns how many further edges it took for done to appear; a timeout is a failure.
    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (!done && edges < budget) begin
            step(1);
            edges++;
        end
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        int e;
        int dc;

        vecs[0]  = mk(1, 0, 0, 5'd3, 1,  1, 4'd1, 0, 1, 0, "t1_fetch_e0");
        vecs[1]  = mk(0, 0, 0, 5'd3, 1,  1, 4'd1, 0, 1, 0, "t1_fetch_e1");
        vecs[2]  = mk(0, 0, 0, 5'd3, 1,  1, 4'd1, 1, 1, 0, "t1_note_e2");
        vecs[3]  = mk(0, 0, 0, 5'd3, 7,  1, 4'd1, 1, 1, 0, "t1_note_e9");
        vecs[4]  = mk(0, 0, 0, 5'd3, 1,  1, 4'd1, 0, 1, 0, "t1_gap_e10");
        vecs[5]  = mk(0, 0, 0, 5'd3, 2,  1, 4'd2, 0, 1, 0, "t1_fetch2_e12");
        vecs[6]  = mk(0, 0, 0, 5'd3, 1,  1, 4'd2, 0, 1, 0, "t1_fetch2_e13");
        vecs[7]  = mk(0, 0, 0, 5'd3, 1,  1, 4'd2, 1, 1, 0, "t1_note2_e14");
        vecs[8]  = mk(0, 0, 0, 5'd3, 10, 1, 4'd3, 0, 1, 0, "t1_fetch3_e24");
        vecs[9]  = mk(0, 0, 0, 5'd3, 2,  1, 4'd3, 1, 1, 0, "t1_note3_e26");
        vecs[10] = mk(0, 0, 0, 5'd3, 8,  1, 4'd3, 0, 1, 0, "t1_gap3_e34");
        vecs[11] = mk(0, 0, 0, 5'd3, 1,  1, 4'd3, 0, 1, 0, "t1_gap3_e35");
        vecs[12] = mk(0, 0, 0, 5'd3, 1,  0, 4'd3, 0, 1, 1, "t1_done_e36");
        vecs[13] = mk(0, 0, 0, 5'd3, 1,  0, 4'd3, 0, 0, 0, "t1_idle_e37");
        vecs[14] = mk(1, 0, 0, 5'd0, 2,  0, 4'd3, 0, 0, 0, "t5_zero_notes");
        vecs[15] = mk(1, 1, 0, 5'd3, 2,  0, 4'd3, 0, 0, 0, "t5_start_stop");

        step(2);
        checkOutput("reset_state", int'(outs()), int'({1'b0, 4'd1, 1'b0, 1'b0, 1'b0}));
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);
        checkOutput("t1_done_count", done_count, 1);

        // 16 notes: slots 1..15 then wrap to 0, done at edge 16*12
        bursts.delete();
        dc = done_count;
        pulse_start(5'd16);
        wait_done(400, e);
        checkOutput("t2_done_edge", e, 192);
        step(1);
        checkOutput("t2_bursts", bursts.size(), 16);
        for (int k = 0; k < 16 && k < bursts.size(); k++)
            checkOutput($sformatf("t2_slot%0d", k), int'(bursts[k]), (k + 1) % 16);
        checkOutput("t2_done_count", done_count - dc, 1);
        checkOutput("t2_idle_busy", int'(busy), 0);

        // num_notes above 16 behaves like 16
        pulse_start(5'd20);
        wait_done(400, e);
        checkOutput("clamp_done_edge", e, 192);
        step(2);

        // looping pass, loop_en cleared during the second pass
        bursts.delete();
        dc = done_count;
        loop_en = 1'b1;
        pulse_start(5'd2);
        step(30);
        loop_en = 1'b0;
        wait_done(100, e);
        checkOutput("t3_done_edge", 30 + e, 48);
        step(1);
        checkOutput("t3_bursts", bursts.size(), 4);
        for (int k = 0; k < 4 && k < bursts.size(); k++)
            checkOutput($sformatf("t3_slot%0d", k), int'(bursts[k]), (k % 2) + 1);
        checkOutput("t3_done_count", done_count - dc, 1);

        // stop during NOTE of slot 2
        pulse_start(5'd3);
        step(16);
        checkOutput("t4_in_note2", int'(outs()), int'({1'b1, 4'd2, 1'b1, 1'b1, 1'b0}));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        checkOutput("t4_stop_edge", int'(outs()), int'({1'b0, 4'd2, 1'b0, 1'b1, 1'b1}));
        step(1);
        checkOutput("t4_idle", int'(outs()), int'({1'b0, 4'd2, 1'b0, 1'b0, 1'b0}));
        pulse_start(5'd1);
        checkOutput("t4_restart", int'(outs()), int'({1'b1, 4'd1, 1'b0, 1'b1, 1'b0}));
        wait_done(100, e);
        checkOutput("t4_restart_done_edge", e, 12);
        step(2);

        // start while busy is ignored
        bursts.delete();
        dc = done_count;
        pulse_start(5'd3);
        step(4);
        pulse_start(5'd1);
        checkOutput("t5_busy_start", int'(outs()), int'({1'b1, 4'd1, 1'b1, 1'b1, 1'b0}));
        wait_done(100, e);
        checkOutput("t5_busy_done_edge", 5 + e, 36);
        step(1);
        checkOutput("t5_busy_bursts", bursts.size(), 3);
        checkOutput("t5_busy_done_count", done_count - dc, 1);

        // asynchronous reset mid-GAP of slot 2
        dc = done_count;
        pulse_start(5'd3);
        step(22);
        checkOutput("t6_in_gap2", int'(outs()), int'({1'b1, 4'd2, 1'b0, 1'b1, 1'b0}));
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_async_reset", int'(outs()), int'({1'b0, 4'd1, 1'b0, 1'b0, 1'b0}));
        #3 reset = 1'b1;
        step(3);
        checkOutput("t6_after_reset", int'(outs()), int'({1'b0, 4'd1, 1'b0, 1'b0, 1'b0}));
        checkOutput("t6_no_done", done_count - dc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
